// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped countdown timer (CTRL/PRESET/COUNT) with registered irq.
// Define TIMER_RELOAD_EN to store MODE and enable auto-reload from INT back to LOAD.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    state_t      state_q, state_d;
    logic        en_q, en_d, im_q, im_d, pend_q, pend_d, irq_q, irq_d;
    logic [31:0] preset_q, preset_d, count_q, count_d;
    logic [1:0]  mode;
    logic        reload, wr, wr_ctrl, wr_ctrl_b0, wr_pre, fsm_clr, enter_int;
    logic        unused_addr;
    assign unused_addr = ^addr[1:0];
    assign hit        = addr[31:4] == BASE_ADDR[31:4];
    assign wr         = hit && byteen != 4'b0000;
    assign wr_ctrl    = wr && addr[3:2] == 2'd0;
    assign wr_ctrl_b0 = wr_ctrl && byteen[0];
    assign wr_pre     = wr && addr[3:2] == 2'd1;
    assign irq        = irq_q;
`ifdef TIMER_RELOAD_EN
    logic [1:0] mode_q, mode_d;
    assign mode   = mode_q;
    assign reload = mode_q == 2'b01;
    always_comb mode_d = wr_ctrl_b0 ? wdata[2:1] : mode_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) mode_q <= 2'b00;
        else       mode_q <= mode_d;
`else
    assign mode   = 2'b00;
    assign reload = 1'b0;
`endif
    always_comb
        rdata = !hit               ? 32'h0 :
                addr[3:2] == 2'd0  ? {28'h0, im_q, mode, en_q} :
                addr[3:2] == 2'd1  ? preset_q :
                addr[3:2] == 2'd2  ? count_q : 32'h0;
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        fsm_clr = 1'b0;
        case (state_q)
            IDLE: if (en_q) state_d = LOAD;
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT:
                if (!en_q)               state_d = IDLE;
                else if (count_q == 0)   state_d = INT;
                else                     count_d = count_q - 32'd1;
            INT:
                if (reload) state_d = LOAD;
                else begin
                    state_d = IDLE;
                    fsm_clr = 1'b1;
                end
            default: state_d = IDLE;
        endcase
    end
    // A CPU write to CTRL byte 0 overrides the FSM clearing EN in the same cycle.
    always_comb begin
        enter_int = state_q == CNT && state_d == INT;
        en_d      = wr_ctrl_b0 ? wdata[0] : (en_q & ~fsm_clr);
        im_d      = wr_ctrl_b0 ? wdata[3] : im_q;
        pend_d    = enter_int ? 1'b1 : (wr_ctrl || wr_pre) ? 1'b0 : pend_q;
        irq_d     = pend_d & im_d;
        for (int i = 0; i < 4; i++)
            preset_d[8*i +: 8] = (wr_pre && byteen[i]) ? wdata[8*i +: 8] : preset_q[8*i +: 8];
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            im_q     <= 1'b0;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
            preset_q <= 32'h0;
            count_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            im_q     <= im_d;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
            preset_q <= preset_d;
            count_q  <= count_d;
        end
endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped countdown timer attached directly downstream of the core's data-memory port (`m_data_addr` / `m_data_wdata` / `m_data_byteen` / `m_data_rdata`). A system bus decoder steers M-stage accesses to it when `hit` is high. It holds three word registers (CTRL, PRESET, COUNT), runs a four-state countdown FSM, and raises an interrupt request on expiry. Reads are combinational so the M stage sees data in the same cycle.

## Interface
- `BASE_ADDR`, default 32'h0000_7F00: byte address of CTRL, 16-byte aligned; window is BASE_ADDR..BASE_ADDR+15.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `addr`  in  32  byte address from the core's M stage.
- `wdata`  in  32  byte-lane-aligned write data.
- `byteen`  in  4  byte write enables; any bit set means a write.
- `hit`  out  1  combinational; high when `addr[31:4] == BASE_ADDR[31:4]`.
- `rdata`  out  32  combinational read data.
- `irq`  out  1  interrupt request, registered.

## Operation
- Register map by `addr[3:2]`; `addr[1:0]` is ignored.
  - 0 = CTRL: bit0 EN, bits2:1 MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (interrupt mask, 1 = enabled). Bits31:4 read 0.
  - 1 = PRESET: 32-bit reload value.
  - 2 = COUNT: read-only; writes are ignored.
  - 3 = reserved: reads 0, writes ignored.
- A write happens when `hit && byteen != 0`. Each register byte i takes `wdata[8i+7:8i]` when `byteen[i]`; other bytes are kept.
- `rdata` returns the addressed register when `hit`, otherwise 0.
- PEND flag: set on entry to INT. Cleared by any write to CTRL or PRESET.
- `irq = PEND & IM`, driven from a flop, so it is glitch-free.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT: if !EN, go to IDLE with COUNT held. Else if COUNT == 0, go to INT. Else COUNT <= COUNT - 1.
  - INT: if MODE == 01, go to LOAD. Otherwise clear EN and go to IDLE.
- COUNT is never decremented below 0; subtraction is 32-bit unsigned.

## Timing
- Reset (async): CTRL = PRESET = COUNT = 0, PEND = 0, state IDLE, `irq` = 0. `hit`/`rdata` follow `addr` combinationally; `rdata` reads 0 for every register.
- Latency, with the write setting EN at edge E0 and PRESET = N:
  - E1: LOAD.
  - E2: COUNT = N, state CNT.
  - E3..E(2+N): COUNT decrements to 0.
  - E(3+N): state INT, PEND = 1; `irq` high after this edge if IM.
  - E(4+N): IDLE (one-shot) or LOAD (auto-reload).
  - One-shot period is N+4 cycles from E0 to IDLE. Auto-reload period is N+3 cycles between INT entries.
- N = 0: INT at E3.
- Write to PRESET while in CNT: does not affect COUNT until the next LOAD. It also clears PEND.
- A CPU write to CTRL in the same cycle the FSM clears EN (INT, one-shot): the CPU value wins, and the FSM still goes to IDLE.
- Clearing EN during LOAD: LOAD completes, then CNT sees !EN and goes to IDLE.
- A read and a write in the same cycle: `rdata` shows the pre-write value.
- Reset mid-count: immediate return to reset values. No `irq` pulse.

## Configuration
- `TIMER_RELOAD_EN` defined: MODE 01 reloads as described.
- `TIMER_RELOAD_EN` undefined:
  - MODE bits are not stored and read 0.
  - INT always clears EN and goes to IDLE.
  - The reload path from INT to LOAD is not synthesised.

## Test plan
- Reset, then read offsets 0/4/8/C at BASE_ADDR -> all 0, `irq` 0, `hit` 1. Read BASE_ADDR+16 -> `hit` 0, `rdata` 0.
- PRESET = 5, CTRL = 32'h9 (EN, IM, one-shot) -> COUNT reads 5,4,3,2,1,0; `irq` rises 8 cycles after the CTRL write edge; CTRL later reads 32'h8; `irq` stays high until a CTRL write of 32'h8 drops it next cycle.
- `TIMER_RELOAD_EN` build, PRESET = 2, CTRL = 32'hB -> INT entered every 5 cycles, repeatedly. Non-`TIMER_RELOAD_EN` build, same stimulus -> a single expiry and CTRL reads 32'h8.
- Byte write `byteen` = 4'b0010, `wdata` = 32'h0000_AB00 to PRESET holding 32'h1122_3344 -> PRESET reads 32'h1122_AB44. Write 32'hFFFF to COUNT -> unchanged.
- PRESET = 100, start, clear EN after 10 cycles -> COUNT freezes at its current value and `irq` stays 0. Assert `reset` mid-count -> all registers 0 within the same cycle.
- IM = 0 with PRESET = 0 and EN set -> expiry sets PEND but `irq` stays 0. Then write CTRL = 32'h8 -> PEND clears, `irq` remains 0.
